vliw_fetch_unit: RTL and testbench
==================================

# vliw_fetch_unit

Fetch stage of the VLIW pipeline: holds the PC, issues one bundle request at a time to instruction memory, and owns the IF/ID pipeline register. It consumes the stall controls (pc_write, ifid_write) and redirect controls (branch/jump PC select, IF/ID flush) produced by the hazard units. Each 48-bit bundle is split into the 16-bit and 32-bit slot instructions for decode.

## Interface
- PC_WIDTH, 32, width of bundle address (word-addressed: one bundle per address)
- RESET_PC, 0, first bundle address fetched after reset
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pc_write  in  1  0 = freeze PC, suppress new requests
- ifid_write  in  1  0 = hold IF/ID register
- ifid_flush  in  1  1 = invalidate IF/ID register at next edge
- branch_pc_src  in  1  redirect to branch_target
- branch_target  in  PC_WIDTH  branch destination
- jump_pc_src  in  1  redirect to jump_target
- jump_target  in  PC_WIDTH  jump destination
- imem_req  out  1  request valid
- imem_addr  out  PC_WIDTH  requested bundle address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid (≥1 cycle after grant)
- imem_rdata  in  48  bundle; [47:32] 16-bit slot, [31:0] 32-bit slot
- ifid_valid  out  1  IF/ID holds a live bundle
- ifid_pc  out  PC_WIDTH  address of bundle in IF/ID
- ifid_instr16  out  16  16-bit slot instruction
- ifid_instr32  out  32  32-bit slot instruction

## Operation
- States: IDLE, REQ, WAIT, DROP, HOLD. At most one outstanding request.
- Redirect = branch_pc_src | jump_pc_src; target = branch_target if branch_pc_src else jump_target (branch wins if both).
- IDLE: reset state; -> REQ next cycle unconditionally.
- REQ: imem_req = pc_write; imem_addr = pc. On req&gnt: req_pc <= pc, pc <= pc+1 (wraps modulo 2^PC_WIDTH), -> WAIT.
- WAIT: on rvalid with ifid_write=1 -> load IF/ID {req_pc, rdata}, -> REQ; with ifid_write=0 -> capture into hold buffer, -> HOLD.
- HOLD: when ifid_write=1 -> load IF/ID from buffer, -> REQ.
- DROP: on rvalid discard data, -> REQ.
- Redirect in any state: pc <= target (overrides increment and pc_write). REQ with gnt same cycle -> DROP; REQ without gnt -> REQ. WAIT without rvalid -> DROP; WAIT with rvalid -> discard, REQ. HOLD -> discard buffer, REQ. DROP stays DROP.
- ifid_flush: ifid_valid <= 0 at next edge; overrides any load that cycle. Does not affect hold buffer or outstanding request (hazard units always pair flush with redirect when a fetch must be killed).
- IF/ID loads only when ifid_write=1; otherwise all IF/ID fields hold.

## Timing
- Reset (async, rst_n low): state IDLE, pc = RESET_PC, imem_req 0, imem_addr RESET_PC, ifid_valid 0, ifid_pc 0, ifid_instr16 0, ifid_instr32 0, hold buffer empty.
- First request: imem_req high in the second cycle after rst_n rises (IDLE then REQ).
- Latency: rvalid in cycle N, ifid_valid/data visible from cycle N+1; next request asserted in cycle N+1. Zero-wait memory sustains one bundle per 2 cycles minimum (request, response).
- Redirect in cycle N: imem_addr = target in cycle N+1 if no drop pending; stale response never reaches IF/ID.
- rst_n asserted mid-transaction: all state cleared immediately; any later rvalid for the abandoned request is ignored (IDLE/REQ ignore rvalid).

## Structure
- Package vliw_fetch_pkg: state enumeration, INSTR16_W=16, INSTR32_W=32, BUNDLE_W=48, slot bit-range constants.
- Sub-module ifid_register: IF/ID storage with write-enable, flush, async active-low reset; fetch FSM and PC stay in vliw_fetch_unit.

## Test plan
- Reset release, zero-wait memory returning rdata = address-tagged bundles -> ifid_pc 0,1,2… each 2 cycles; instr16/instr32 match slices.
- ifid_write=0 for 3 cycles while response arrives (pc 5) -> FSM in HOLD, IF/ID unchanged; on release IF/ID shows pc 5, no bundle lost or duplicated.
- branch_pc_src=1, target 0x40, while WAIT on pc 7 -> DROP; response for 7 discarded; next imem_addr 0x40, next ifid_pc 0x40.
- branch_pc_src and jump_pc_src both 1 (targets 0x10/0x20) -> pc 0x10.
- pc_write=0 in REQ -> imem_req 0, imem_addr stable; resumes same address when released.
- rst_n low during WAIT, late rvalid afterwards -> ifid_valid stays 0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/vliw_fetch_pkg.sv
// Shared types and constants for the VLIW fetch stage.
// A bundle is 48 bits: the 16-bit slot sits in the top bits and the 32-bit slot in the low bits.
package vliw_fetch_pkg;

  localparam int unsigned INSTR16_W  = 16;
  localparam int unsigned INSTR32_W  = 32;
  localparam int unsigned BUNDLE_W   = 48;
  localparam int unsigned SLOT16_MSB = 47;
  localparam int unsigned SLOT16_LSB = 32;
  localparam int unsigned SLOT32_MSB = 31;
  localparam int unsigned SLOT32_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } fetch_state_t;

  function automatic logic [INSTR16_W-1:0] slot16(input logic [BUNDLE_W-1:0] bundle);
    return bundle[SLOT16_MSB:SLOT16_LSB];
  endfunction

  function automatic logic [INSTR32_W-1:0] slot32(input logic [BUNDLE_W-1:0] bundle);
    return bundle[SLOT32_MSB:SLOT32_LSB];
  endfunction

endpackage

// File: rtl/vliw_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface vliw_fetch_if #(
  parameter int unsigned PC_WIDTH = 32
);
  import vliw_fetch_pkg::*;

  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  logic [BUNDLE_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/vliw_fetch_ifid_register.sv
// IF/ID pipeline register: valid bit plus PC and split slot instructions.
// An enabled write with no load inserts a bubble; flush clears valid and wins over a load.
module ifid_register
  import vliw_fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write_en,
  input  logic                 flush,
  input  logic                 load,
  input  logic [PC_WIDTH-1:0]  load_pc,
  input  logic [BUNDLE_W-1:0]  load_bundle,
  output logic                 valid,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [INSTR16_W-1:0] instr16,
  output logic [INSTR32_W-1:0] instr32
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      pc      <= '0;
      instr16 <= '0;
      instr32 <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (write_en) begin
        valid <= load;
      end
      if (write_en && load && !flush) begin
        pc      <= load_pc;
        instr16 <= slot16(load_bundle);
        instr32 <= slot32(load_bundle);
      end
    end
  end

endmodule

// File: rtl/vliw_fetch_unit.sv
// Fetch stage: PC, single-outstanding instruction-memory requests, redirect handling
// and the IF/ID register.
module vliw_fetch_unit
  import vliw_fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pc_write,
  input  logic                 ifid_write,
  input  logic                 ifid_flush,
  input  logic                 branch_pc_src,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic                 jump_pc_src,
  input  logic [PC_WIDTH-1:0]  jump_target,
  vliw_fetch_if.master         imem,
  output logic                 ifid_valid,
  output logic [PC_WIDTH-1:0]  ifid_pc,
  output logic [INSTR16_W-1:0] ifid_instr16,
  output logic [INSTR32_W-1:0] ifid_instr32
);

  fetch_state_t        state;
  fetch_state_t        state_next;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] req_pc;
  logic [BUNDLE_W-1:0] hold_data;

  logic                redirect;
  logic [PC_WIDTH-1:0] target;
  logic                accept;
  logic                ifid_load;
  logic [BUNDLE_W-1:0] load_bundle;
  logic                hold_capture;

  assign redirect = branch_pc_src | jump_pc_src;
  assign target   = branch_pc_src ? branch_target : jump_target;
  assign accept   = imem.imem_req & imem.imem_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (accept) state_next = redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (redirect)                state_next = imem.imem_rvalid ? S_REQ : S_DROP;
        else if (imem.imem_rvalid)   state_next = ifid_write ? S_REQ : S_HOLD;
      end
      S_HOLD: begin
        if (redirect || ifid_write) state_next = S_REQ;
      end
      S_DROP: begin
        if (imem.imem_rvalid) state_next = S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A redirect kills whatever response arrives in the same cycle, whether from memory or the buffer.
  always_comb begin
    imem.imem_req  = (state == S_REQ) & pc_write;
    imem.imem_addr = pc;
    ifid_load      = !redirect && ifid_write &&
                     (((state == S_WAIT) && imem.imem_rvalid) || (state == S_HOLD));
    load_bundle    = (state == S_HOLD) ? hold_data : imem.imem_rdata;
    hold_capture   = (state == S_WAIT) && imem.imem_rvalid && !ifid_write && !redirect;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      req_pc    <= '0;
      hold_data <= '0;
    end else begin
      if (redirect) begin
        pc <= target;
      end else if ((state == S_REQ) && accept) begin
        pc <= pc + 1'b1;
      end
      if ((state == S_REQ) && accept) begin
        req_pc <= pc;
      end
      if (hold_capture) begin
        hold_data <= imem.imem_rdata;
      end
    end
  end

  ifid_register #(
    .PC_WIDTH(PC_WIDTH)
  ) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (ifid_write),
    .flush      (ifid_flush),
    .load       (ifid_load),
    .load_pc    (req_pc),
    .load_bundle(load_bundle),
    .valid      (ifid_valid),
    .pc         (ifid_pc),
    .instr16    (ifid_instr16),
    .instr32    (ifid_instr32)
  );

endmodule

// File: tb/tb_vliw_fetch_unit.sv
// Directed bench for vliw_fetch_unit: a memory responder returns address-tagged bundles,
// expected PCs are queued as fetches are set up and checked as bundles reach IF/ID.
module tb_vliw_fetch_unit;
  import vliw_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        branch_pc_src;
  logic [31:0] branch_target;
  logic        jump_pc_src;
  logic [31:0] jump_target;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [15:0] ifid_instr16;
  logic [31:0] ifid_instr32;

  int          passed = 0;
  int          total  = 0;
  int          mem_delay = 0;
  logic [31:0] acc_addr;
  logic [31:0] sb[$];

  vliw_fetch_if #(.PC_WIDTH(32)) bus ();

  vliw_fetch_unit #(
    .PC_WIDTH(32),
    .RESET_PC(32'h0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .branch_pc_src(branch_pc_src),
    .branch_target(branch_target),
    .jump_pc_src  (jump_pc_src),
    .jump_target  (jump_target),
    .imem         (bus),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_instr16 (ifid_instr16),
    .ifid_instr32 (ifid_instr32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] tag(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3C3, a ^ 32'hA5A5_0000};
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Memory: grant is driven by the sequence; data returns 1+mem_delay cycles after the grant.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.imem_req && bus.imem_gnt) begin
        acc_addr = bus.imem_addr;
        repeat (mem_delay) @(negedge clk);
        @(posedge clk);
        #2;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = tag(acc_addr);
        @(posedge clk);
        #2;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end
    end
  end

  // Scoreboard: each bundle that decode consumes must be the next expected PC with matching slots.
  always @(negedge clk) begin
    if (rst_n && ifid_valid && ifid_write) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_bundle", 64'(sb.size()), 64'd1);
      end else begin
        automatic logic [31:0] exp_pc = sb.pop_front();
        automatic logic [47:0] exp_b  = tag(exp_pc);
        check("sb_ifid_pc", ifid_pc, exp_pc);
        check("sb_instr16", ifid_instr16, exp_b[47:32]);
        check("sb_instr32", ifid_instr32, exp_b[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    branch_pc_src = 1'b0;
    branch_target = '0;
    jump_pc_src   = 1'b0;
    jump_target   = '0;
    bus.imem_gnt  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", ifid_valid, 1'b0);
    check("rst_ifid_pc", ifid_pc, 32'h0);
    check("rst_instr16", ifid_instr16, 16'h0);
    check("rst_instr32", ifid_instr32, 32'h0);

    // Zero-wait streaming: grants in cycles 1,3,5,7,9 -> bundles 0..4.
    for (int k = 0; k < 5; k++) sb.push_back(32'(k));
    bus.imem_gnt = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("thru_valid", ifid_valid, (i >= 3 && (i % 2) == 1));
      if (i == 0) check("first_req_idle", bus.imem_req, 1'b0);
      if (i == 1) begin
        check("first_req", bus.imem_req, 1'b1);
        check("first_addr", bus.imem_addr, 32'h0);
      end
      if (i == 11) check("thru_next_addr", bus.imem_addr, 32'd5);
      next_cycle();
      if (i == 9) bus.imem_gnt = 1'b0;
    end

    // Decode stall while the response for pc 5 arrives.
    bus.imem_gnt = 1'b1;
    sb.push_back(32'd5);
    next_cycle();
    bus.imem_gnt = 1'b0;
    ifid_write   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      check("hold_valid", ifid_valid, 1'b0);
      check("hold_ifid_pc", ifid_pc, 32'd4);
      check("hold_no_req", bus.imem_req, 1'b0);
    end
    next_cycle();
    ifid_write = 1'b1;
    @(negedge clk);
    check("hold_release_pending", ifid_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    check("hold_out_valid", ifid_valid, 1'b1);
    check("hold_out_pc", ifid_pc, 32'd5);
    check("hold_next_addr", bus.imem_addr, 32'd6);

    // Branch while waiting on pc 7: its response is dropped, fetch resumes at 0x40.
    next_cycle();
    bus.imem_gnt = 1'b1;
    mem_delay    = 1;
    sb.push_back(32'd6);
    sb.push_back(32'h40);
    repeat (4) next_cycle();
    branch_pc_src = 1'b1;
    branch_target = 32'h40;
    @(negedge clk);
    check("br_wait_no_req", bus.imem_req, 1'b0);
    next_cycle();
    branch_pc_src = 1'b0;
    @(negedge clk);
    check("br_drop_no_req", bus.imem_req, 1'b0);
    check("br_drop_addr", bus.imem_addr, 32'h40);
    next_cycle();
    @(negedge clk);
    check("br_req", bus.imem_req, 1'b1);
    check("br_addr", bus.imem_addr, 32'h40);
    next_cycle();
    bus.imem_gnt = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("br_ifid_valid", ifid_valid, 1'b1);
    check("br_ifid_pc", ifid_pc, 32'h40);
    check("br_next_addr", bus.imem_addr, 32'h41);

    // Branch and jump together: branch target wins.
    next_cycle();
    mem_delay     = 0;
    branch_pc_src = 1'b1;
    branch_target = 32'h10;
    jump_pc_src   = 1'b1;
    jump_target   = 32'h20;
    next_cycle();
    branch_pc_src = 1'b0;
    jump_pc_src   = 1'b0;
    bus.imem_gnt  = 1'b1;
    sb.push_back(32'h10);
    @(negedge clk);
    check("both_req", bus.imem_req, 1'b1);
    check("both_addr", bus.imem_addr, 32'h10);
    next_cycle();
    bus.imem_gnt = 1'b0;
    next_cycle();
    @(negedge clk);
    check("both_ifid_pc", ifid_pc, 32'h10);
    next_cycle();
    jump_pc_src = 1'b1;
    jump_target = 32'h33;
    next_cycle();
    jump_pc_src = 1'b0;
    @(negedge clk);
    check("jump_addr", bus.imem_addr, 32'h33);

    // PC freeze: no request while pc_write is low, same address afterwards.
    next_cycle();
    pc_write     = 1'b0;
    bus.imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("frz_req", bus.imem_req, 1'b0);
      check("frz_addr", bus.imem_addr, 32'h33);
      next_cycle();
    end
    pc_write = 1'b1;
    sb.push_back(32'h33);
    @(negedge clk);
    check("frz_resume_req", bus.imem_req, 1'b1);
    check("frz_resume_addr", bus.imem_addr, 32'h33);
    next_cycle();
    bus.imem_gnt = 1'b0;
    next_cycle();
    @(negedge clk);
    check("frz_ifid_pc", ifid_pc, 32'h33);

    // Flush on the response cycle: bundle 0x34 never becomes valid.
    next_cycle();
    bus.imem_gnt = 1'b1;
    next_cycle();
    bus.imem_gnt = 1'b0;
    ifid_flush   = 1'b1;
    next_cycle();
    ifid_flush = 1'b0;
    @(negedge clk);
    check("flush_valid", ifid_valid, 1'b0);
    check("flush_next_addr", bus.imem_addr, 32'h35);

    // Reset during WAIT; the abandoned response arrives while the FSM sits in REQ.
    next_cycle();
    bus.imem_gnt = 1'b1;
    mem_delay    = 3;
    next_cycle();
    bus.imem_gnt = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("mid_rst_req", bus.imem_req, 1'b0);
    check("mid_rst_addr", bus.imem_addr, 32'h0);
    check("mid_rst_valid", ifid_valid, 1'b0);
    check("mid_rst_ifid_pc", ifid_pc, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("late_rvalid_ignored", ifid_valid, 1'b0);
    check("restart_req", bus.imem_req, 1'b1);
    check("restart_addr", bus.imem_addr, 32'h0);
    next_cycle();
    mem_delay    = 0;
    bus.imem_gnt = 1'b1;
    sb.push_back(32'h0);
    next_cycle();
    bus.imem_gnt = 1'b0;
    next_cycle();
    @(negedge clk);
    check("restart_ifid_valid", ifid_valid, 1'b1);
    check("restart_ifid_pc", ifid_pc, 32'h0);

    repeat (4) next_cycle();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
